// File: rtl/qed_dup_scheduler_if.sv
// Handshake/status bundle between fetch, pipeline status, the QED block and the scheduler.
// The scheduler connects through the slave modport; the driving environment uses master.
interface qed_dup_scheduler_if #(
  parameter int CNT_W = 5
);
  logic             qed_enable;
  logic             dup_req;
  logic             inst_fetched;
  logic             dup_vld;
  logic             stall_IF;
  logic             pipeline_empty;
  logic             ena;
  logic             exec_dup;
  logic             fetch_hold;
  logic             qed_check;
  logic             qed_timeout;
  logic [CNT_W-1:0] orig_cnt;

  modport slave (
    input  qed_enable, dup_req, inst_fetched, dup_vld, stall_IF, pipeline_empty,
    output ena, exec_dup, fetch_hold, qed_check, qed_timeout, orig_cnt
  );

  modport master (
    output qed_enable, dup_req, inst_fetched, dup_vld, stall_IF, pipeline_empty,
    input  ena, exec_dup, fetch_hold, qed_check, qed_timeout, orig_cnt
  );
endinterface

// File: rtl/qed_dup_scheduler.sv
// QED front-end sequencer: collects a batch of originals, replays the same number of
// duplicates, drains the pipeline and strobes a consistency check.
module qed_dup_scheduler #(
  parameter int MAX_ORIG  = 16,
  parameter int CNT_W     = 5,
  parameter int DRAIN_MAX = 64
) (
  input logic             clk,
  input logic             rst,
  qed_dup_scheduler_if.slave bus
);
  localparam int TMR_W = (DRAIN_MAX > 2) ? $clog2(DRAIN_MAX) : 1;
  localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_ORIG);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DRAIN_MAX - 1);

  typedef enum logic [2:0] {IDLE, ORIG, DUP, DRAIN, CHECK} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] orig_cnt, dup_cnt, orig_nxt, dup_nxt, n_o, n_d;
  logic [TMR_W-1:0] drain_tmr, tmr_nxt;
  logic             acc_o, acc_d, timeout_nxt;
  logic             ena, exec_dup, fetch_hold, qed_check, qed_timeout;

  always_comb begin
    acc_o       = bus.inst_fetched & ~bus.stall_IF;
    acc_d       = bus.dup_vld & ~bus.stall_IF;
    n_o         = orig_cnt + CNT_W'(acc_o);
    n_d         = dup_cnt + CNT_W'(acc_d);
    state_nxt   = state;
    orig_nxt    = orig_cnt;
    dup_nxt     = dup_cnt;
    tmr_nxt     = drain_tmr;
    timeout_nxt = qed_timeout;
    case (state)
      IDLE: if (bus.qed_enable) state_nxt = ORIG;
      ORIG: begin
        orig_nxt = (n_o > MAX_C) ? MAX_C : n_o;
        // Losing enable mid-batch finishes the batch rather than dropping it.
        if (orig_nxt == MAX_C)
          state_nxt = DUP;
        else if ((bus.dup_req || !bus.qed_enable) && orig_nxt != '0)
          state_nxt = DUP;
        else if (!bus.qed_enable)
          state_nxt = IDLE;
      end
      DUP: begin
        dup_nxt = n_d;
        if (n_d == orig_cnt) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (bus.pipeline_empty) begin
          state_nxt = CHECK;
        end else if (drain_tmr == TMR_LAST) begin
          timeout_nxt = 1'b1;
          state_nxt   = IDLE;
          orig_nxt    = '0;
          dup_nxt     = '0;
          tmr_nxt     = '0;
        end else begin
          tmr_nxt = drain_tmr + 1'b1;
        end
      end
      CHECK: begin
        orig_nxt  = '0;
        dup_nxt   = '0;
        tmr_nxt   = '0;
        state_nxt = bus.qed_enable ? ORIG : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the registered state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      orig_cnt    <= '0;
      dup_cnt     <= '0;
      drain_tmr   <= '0;
      qed_timeout <= 1'b0;
      ena         <= 1'b0;
      exec_dup    <= 1'b0;
      fetch_hold  <= 1'b0;
      qed_check   <= 1'b0;
    end else begin
      state       <= state_nxt;
      orig_cnt    <= orig_nxt;
      dup_cnt     <= dup_nxt;
      drain_tmr   <= tmr_nxt;
      qed_timeout <= timeout_nxt;
      ena         <= (state_nxt == ORIG) || (state_nxt == DUP);
      exec_dup    <= (state_nxt == DUP);
      fetch_hold  <= (state_nxt == DRAIN) || (state_nxt == CHECK);
      qed_check   <= (state_nxt == CHECK);
    end
  end

  assign bus.ena         = ena;
  assign bus.exec_dup    = exec_dup;
  assign bus.fetch_hold  = fetch_hold;
  assign bus.qed_check   = qed_check;
  assign bus.qed_timeout = qed_timeout;
  assign bus.orig_cnt    = orig_cnt;
endmodule
